// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit.
// MCCTRL_CMP_EN adds CMP/TST as flag-only data-processing commands.
package mc_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecuteR,
      StExecuteI,
      StAluWb,
      StBranch
   } state_e;

   localparam logic [1:0] AluAdd = 2'b00;
   localparam logic [1:0] AluSub = 2'b01;
   localparam logic [1:0] AluAnd = 2'b10;
   localparam logic [1:0] AluOrr = 2'b11;

   localparam logic [1:0] SrcAReg    = 2'd0;
   localparam logic [1:0] SrcAPc     = 2'd1;
   localparam logic [1:0] SrcAAluOut = 2'd2;

   localparam logic [1:0] SrcBWd   = 2'd0;
   localparam logic [1:0] SrcBImm  = 2'd1;
   localparam logic [1:0] SrcBFour = 2'd2;

   localparam logic [1:0] ResAluOut    = 2'd0;
   localparam logic [1:0] ResData      = 2'd1;
   localparam logic [1:0] ResAluResult = 2'd2;

   localparam logic [1:0] OpDp     = 2'b00;
   localparam logic [1:0] OpMem    = 2'b01;
   localparam logic [1:0] OpBranch = 2'b10;

   localparam logic [3:0] CmdAnd = 4'b0000;
   localparam logic [3:0] CmdSub = 4'b0010;
   localparam logic [3:0] CmdAdd = 4'b0100;
   localparam logic [3:0] CmdTst = 4'b1000;
   localparam logic [3:0] CmdCmp = 4'b1010;
   localparam logic [3:0] CmdOrr = 4'b1100;

   localparam logic [3:0] CondEq = 4'b0000;
   localparam logic [3:0] CondNe = 4'b0001;
   localparam logic [3:0] CondCs = 4'b0010;
   localparam logic [3:0] CondCc = 4'b0011;
   localparam logic [3:0] CondMi = 4'b0100;
   localparam logic [3:0] CondPl = 4'b0101;
   localparam logic [3:0] CondVs = 4'b0110;
   localparam logic [3:0] CondVc = 4'b0111;
   localparam logic [3:0] CondHi = 4'b1000;
   localparam logic [3:0] CondLs = 4'b1001;
   localparam logic [3:0] CondGe = 4'b1010;
   localparam logic [3:0] CondLt = 4'b1011;
   localparam logic [3:0] CondGt = 4'b1100;
   localparam logic [3:0] CondLe = 4'b1101;
   localparam logic [3:0] CondAl = 4'b1110;

   typedef struct packed {
      logic [1:0] alu_ctrl;
      logic       no_wr;    // command never writes the register file
      logic [1:0] flag_w;   // [1] NZ, [0] CV requested (before CondEx)
   } alu_dec_t;

   // funct[4:1] is the ARM command, funct[0] the S bit.
   function automatic alu_dec_t alu_decode(input logic [4:0] funct);
      alu_dec_t d;
      logic     s;
      s          = funct[0];
      d.alu_ctrl = AluAdd;
      d.no_wr    = 1'b0;
      d.flag_w   = 2'b00;
      case (funct[4:1])
         CmdAdd: begin d.alu_ctrl = AluAdd; d.flag_w = {s, s};    end
         CmdSub: begin d.alu_ctrl = AluSub; d.flag_w = {s, s};    end
         CmdAnd: begin d.alu_ctrl = AluAnd; d.flag_w = {s, 1'b0}; end
         CmdOrr: begin d.alu_ctrl = AluOrr; d.flag_w = {s, 1'b0}; end
`ifdef MCCTRL_CMP_EN
         CmdCmp: begin d.alu_ctrl = AluSub; d.flag_w = {s, s};    d.no_wr = 1'b1; end
         CmdTst: begin d.alu_ctrl = AluAnd; d.flag_w = {s, 1'b0}; d.no_wr = 1'b1; end
`endif
         default: d.no_wr = 1'b1;
      endcase
      return d;
   endfunction

   // flags = {N, Z, C, V}
   function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      logic ex;
      {n, z, c, v} = flags;
      case (cond)
         CondEq:  ex = z;
         CondNe:  ex = ~z;
         CondCs:  ex = c;
         CondCc:  ex = ~c;
         CondMi:  ex = n;
         CondPl:  ex = ~n;
         CondVs:  ex = v;
         CondVc:  ex = ~v;
         CondHi:  ex = c & ~z;
         CondLs:  ex = ~c | z;
         CondGe:  ex = (n == v);
         CondLt:  ex = (n != v);
         CondGt:  ex = ~z & (n == v);
         CondLe:  ex = z | (n != v);
         CondAl:  ex = 1'b1;
         default: ex = 1'b0;
      endcase
      return ex;
   endfunction

endpackage

// File: rtl/cond_logic.sv
// Condition unit: stored NZCV flags, condition evaluation against them, and
// condition-gated flag writes.
module cond_logic
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   output logic       cond_ex
);

   logic [3:0] flags_q, flags_d;

   // Evaluated on the stored flags so an S-instruction cannot gate itself.
   assign cond_ex = cond_check(cond, flags_q);

   always_comb begin
      flags_d = flags_q;
      if (flag_w[1] && cond_ex) flags_d[3:2] = alu_flags[3:2];
      if (flag_w[0] && cond_ex) flags_d[1:0] = alu_flags[1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) flags_q <= 4'b0000;
      else        flags_q <= flags_d;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control unit: Moore main FSM plus output decode.
// Define MCCTRL_CMP_EN to execute CMP/TST as flag-only commands.
module multicycle_ctrl
   import mc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] Instr,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        MemWrite,
   output logic        RegWrite,
   output logic        IRWrite,
   output logic        AdrSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  ALUControl
);

   state_e     state_q, state_d;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       unused_rn;
   alu_dec_t   dec;
   logic       cond_ex;
   logic [1:0] flag_w;
   logic       next_pc, branch, reg_w, mem_w, ir_w;
   logic       cmd_no_wr, pcs;

   assign cond      = Instr[19:16];
   assign op        = Instr[15:14];
   assign funct     = Instr[13:8];
   assign rd        = Instr[3:0];
   assign unused_rn = ^Instr[7:4];

   assign dec = alu_decode(funct[4:0]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StFetch;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = StFetch;
      unique case (state_q)
         StFetch:  state_d = StDecode;
         StDecode: begin
            case (op)
               OpMem:    state_d = StMemAdr;
               OpDp:     state_d = funct[5] ? StExecuteI : StExecuteR;
               OpBranch: state_d = StBranch;
               default:  state_d = StFetch;
            endcase
         end
         StMemAdr:   state_d = funct[0] ? StMemRead : StMemWrite;
         StMemRead:  state_d = StMemWb;
         StMemWb:    state_d = StFetch;
         StMemWrite: state_d = StFetch;
         StExecuteR: state_d = StAluWb;
         StExecuteI: state_d = StAluWb;
         StAluWb:    state_d = StFetch;
         StBranch:   state_d = StFetch;
         default:    state_d = StFetch;
      endcase
   end

   always_comb begin
      next_pc    = 1'b0;
      branch     = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      ir_w       = 1'b0;
      flag_w     = 2'b00;
      AdrSrc     = 1'b0;
      ALUSrcA    = SrcAReg;
      ALUSrcB    = SrcBWd;
      ResultSrc  = ResAluOut;
      ALUControl = AluAdd;
      unique case (state_q)
         StFetch: begin
            ir_w      = 1'b1;
            next_pc   = 1'b1;
            ALUSrcA   = SrcAPc;
            ALUSrcB   = SrcBFour;
            ResultSrc = ResAluResult;
         end
         StDecode: begin
            // PC+8 is produced here and forwarded as R15 for the read ports.
            ALUSrcA   = SrcAPc;
            ALUSrcB   = SrcBFour;
            ResultSrc = ResAluResult;
         end
         StMemAdr:  ALUSrcB = SrcBImm;
         StMemRead: begin
            AdrSrc    = 1'b1;
            ResultSrc = ResAluOut;
         end
         StMemWb: begin
            ResultSrc = ResData;
            reg_w     = 1'b1;
         end
         StMemWrite: begin
            AdrSrc    = 1'b1;
            ResultSrc = ResAluOut;
            mem_w     = 1'b1;
         end
         StExecuteR: begin
            ALUSrcB    = SrcBWd;
            ALUControl = dec.alu_ctrl;
            flag_w     = dec.flag_w;
         end
         StExecuteI: begin
            ALUSrcB    = SrcBImm;
            ALUControl = dec.alu_ctrl;
            flag_w     = dec.flag_w;
         end
         StAluWb: begin
            ResultSrc = ResAluOut;
            reg_w     = 1'b1;
         end
         StBranch: begin
            ALUSrcA   = SrcAAluOut;
            ALUSrcB   = SrcBImm;
            ResultSrc = ResAluResult;
            branch    = 1'b1;
         end
         default: ;
      endcase
   end

   // Register-read selects are a pure function of the instruction class.
   assign RegSrc = {op == OpMem, op == OpBranch};
   assign ImmSrc = op;

   assign cmd_no_wr = (state_q == StAluWb) & dec.no_wr;
   assign pcs       = (rd == 4'hF) & reg_w & ~cmd_no_wr;

   // Enables are held low for the whole time reset is asserted.
   assign PCWrite  = reset & (next_pc | ((branch | pcs) & cond_ex));
   assign RegWrite = reset & reg_w & cond_ex & ~cmd_no_wr;
   assign MemWrite = reset & mem_w & cond_ex;
   assign IRWrite  = reset & ir_w;

   cond_logic u_cond (
      .clk       (clk),
      .reset     (reset),
      .cond      (cond),
      .alu_flags (ALUFlags),
      .flag_w    (flag_w),
      .cond_ex   (cond_ex)
   );

endmodule
